uart_frame_ctrl: RTL and testbench

- Packet-level controller that sits directly behind the UART receiver. Consumes its byte stream (data, valid pulse, frame-error pulse).
- Hunts for a sync byte, then collects opcode, length, payload and checksum. Buffers the payload and presents one validated command at a time to downstream logic through a valid/ready handshake.
- Maintains good/bad packet counters and an inter-byte timeout so a truncated packet cannot stall the link.

---
 rtl/uart_frame_ctrl_if.sv | 36 +++
 rtl/uart_frame_ctrl.sv | 178 +++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_frame_ctrl_if
//   Command-side bus of uart_frame_ctrl: one validated command at a time,
//   offered with a valid/ready handshake, plus a combinational payload read
//   port into the controller's buffer.
//
//   cmd_valid   master->slave  validated command available
//   cmd_ready   slave->master  downstream accepts command
//   cmd_opcode  master->slave  opcode of held command
//   cmd_len     master->slave  payload length of held command
//   rd_idx      slave->master  payload read index
//   rd_data     master->slave  payload byte at rd_idx (0 beyond cmd_len)
// ---------------------------------------------------------------------------
interface uart_frame_ctrl_if #(
  parameter int unsigned MAX_LEN = 16
) ();
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = $clog2(MAX_LEN);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_opcode;
  logic [LW-1:0] cmd_len;
  logic [IW-1:0] rd_idx;
  logic [7:0]    rd_data;

  modport master (
    output cmd_valid, cmd_opcode, cmd_len, rd_data,
    input  cmd_ready, rd_idx
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_len, rd_data,
    output cmd_ready, rd_idx
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_frame_ctrl
//   Packet controller behind a UART receiver. Hunts for SYNC_BYTE, collects
//   OPCODE, LEN, LEN payload bytes and CHK (8-bit wrapping sum of opcode,
//   len and payload), then holds the validated command for downstream until
//   accepted. An inter-byte timeout aborts truncated packets.
//
//   Optional feature: define UART_FRAME_CTRL_STATS_EN to build the saturating
//   good/bad packet counters; otherwise cnt_ok/cnt_err read as zero.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   rx_frame_error    one-cycle receiver stop-bit error strobe
//   cmd               command bus (master side), see uart_frame_ctrl_if
//   cnt_ok, cnt_err   delivered / rejected packet counters
//   busy              high whenever not hunting for sync
//   state             current FSM state (debug)
// ---------------------------------------------------------------------------
module uart_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 43400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_frame_error,
  uart_frame_ctrl_if.master cmd,
  output logic [15:0]       cnt_ok,
  output logic [15:0]       cnt_err,
  output logic              busy,
  output logic [2:0]        state
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = $clog2(MAX_LEN);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    OPCODE  = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CHECK   = 3'd4,
    HOLD    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    opcode_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx_q;
  logic [7:0]    sum_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    buf_q [MAX_LEN];

  logic byte_evt, active, abort_fe, abort_tmo, len_bad, chk_ok, last_pl;

  // A byte coinciding with a frame error is dropped.
  assign byte_evt  = rx_valid && !rx_frame_error;
  assign active    = (state_q == OPCODE) || (state_q == LEN) ||
                     (state_q == PAYLOAD) || (state_q == CHECK);
  assign abort_fe  = active && rx_frame_error;
  assign abort_tmo = active && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign len_bad   = rx_data > 8'(MAX_LEN);
  assign chk_ok    = rx_data == sum_q;
  assign last_pl   = idx_q == (len_q - LW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT: if (byte_evt && rx_data == SYNC_BYTE) state_d = OPCODE;
      HOLD: if (cmd.cmd_ready) state_d = HUNT;
      OPCODE, LEN, PAYLOAD, CHECK: begin
        if (abort_fe || abort_tmo) begin
          state_d = HUNT;
        end else if (byte_evt) begin
          unique case (state_q)
            OPCODE:  state_d = LEN;
            LEN:     state_d = len_bad ? HUNT : ((rx_data == 8'd0) ? CHECK : PAYLOAD);
            PAYLOAD: if (last_pl) state_d = CHECK;
            CHECK:   state_d = chk_ok ? HOLD : HUNT;
            default: state_d = HUNT;
          endcase
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Outputs
  always_comb begin
    cmd.cmd_valid = (state_q == HOLD);
    busy          = (state_q != HUNT);
    state         = state_q;
    cmd.rd_data   = (LW'(cmd.rd_idx) < len_q) ? buf_q[cmd.rd_idx] : 8'h00;
  end

  assign cmd.cmd_opcode = opcode_q;
  assign cmd.cmd_len    = len_q;

  // Packet datapath. Opcode/len registers double as the held command; they
  // only change while a new packet is being collected, never in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      tmo_q    <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
    end else begin
      if (rx_valid || !active) tmo_q <= '0;
      else                     tmo_q <= tmo_q + TW'(1);

      if (!abort_fe && !abort_tmo && byte_evt) begin
        unique case (state_q)
          OPCODE: begin
            opcode_q <= rx_data;
            sum_q    <= rx_data;
          end
          LEN: if (!len_bad) begin
            len_q <= rx_data[LW-1:0];
            sum_q <= sum_q + rx_data;
            idx_q <= '0;
          end
          PAYLOAD: begin
            buf_q[idx_q[IW-1:0]] <= rx_data;
            sum_q <= sum_q + rx_data;
            idx_q <= idx_q + LW'(1);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UART_FRAME_CTRL_STATS_EN
  logic ok_evt, err_evt;

  always_comb begin
    ok_evt  = (state_q == HOLD) && cmd.cmd_ready;
    err_evt = 1'b0;
    if (abort_fe || abort_tmo) begin
      err_evt = 1'b1;
    end else if (byte_evt) begin
      unique case (state_q)
        LEN:     err_evt = len_bad;
        CHECK:   err_evt = !chk_ok;
        HOLD:    err_evt = 1'b1;  // overrun, even on the handshake cycle
        default: err_evt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok  <= '0;
      cnt_err <= '0;
    end else begin
      if (ok_evt && cnt_ok != '1)   cnt_ok  <= cnt_ok + 16'd1;
      if (err_evt && cnt_err != '1) cnt_err <= cnt_err + 16'd1;
    end
  end
`else
  assign cnt_ok  = '0;
  assign cnt_err = '0;
`endif

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_ctrl
//   Directed self-checking bench for uart_frame_ctrl. Counter expectations
//   collapse to zero when UART_FRAME_CTRL_STATS_EN is not defined.
// ---------------------------------------------------------------------------
module tb_uart_frame_ctrl;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TMO     = 43400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_frame_error = 1'b0;
  logic [15:0] cnt_ok, cnt_err;
  logic        busy;
  logic [2:0]  state;

  int unsigned n_vec = 0, n_miss = 0;
  int unsigned exp_ok = 0, exp_err = 0;

  uart_frame_ctrl_if #(.MAX_LEN(MAX_LEN)) cmd_if ();

  uart_frame_ctrl #(
    .SYNC_BYTE      (8'hAA),
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_frame_error (rx_frame_error),
    .cmd            (cmd_if.master),
    .cnt_ok         (cnt_ok),
    .cnt_err        (cnt_err),
    .busy           (busy),
    .state          (state)
  );

  always #10 clk = ~clk;

  function automatic int unsigned stat(input int unsigned n);
`ifdef UART_FRAME_CTRL_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic accept_cmd();
    @(negedge clk);
    cmd_if.cmd_ready = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ready = 1'b0;
  endtask

  task automatic check_rd(input int unsigned idx, input logic [7:0] exp);
    cmd_if.rd_idx = 4'(idx);
    #1;
    check($sformatf("rd_data[%0d]", idx), 32'(cmd_if.rd_data), 32'(exp));
  endtask

  task automatic check_cnts(input string tag);
    check({tag, ".cnt_ok"},  32'(cnt_ok),  stat(exp_ok));
    check({tag, ".cnt_err"}, 32'(cnt_err), stat(exp_err));
  endtask

  initial begin
    cmd_if.cmd_ready = 1'b0;
    cmd_if.rd_idx    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.state",  32'(state), 0);
    check("rst.valid",  32'(cmd_if.cmd_valid), 0);
    check("rst.opcode", 32'(cmd_if.cmd_opcode), 0);
    check("rst.len",    32'(cmd_if.cmd_len), 0);
    check("rst.busy",   32'(busy), 0);
    check_rd(0, 8'h00);
    check_cnts("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Good frame, held until accepted
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h05); send_byte(8'h07);
    check("t1.pre_chk_state", 32'(state), 4);
    check("t1.pre_chk_valid", 32'(cmd_if.cmd_valid), 0);
    send_byte(8'h1E);
    check("t1.valid",  32'(cmd_if.cmd_valid), 1);
    check("t1.state",  32'(state), 5);
    check("t1.opcode", 32'(cmd_if.cmd_opcode), 32'h10);
    check("t1.len",    32'(cmd_if.cmd_len), 2);
    check_rd(0, 8'h05);
    check_rd(1, 8'h07);
    check_rd(2, 8'h00);
    repeat (3) @(negedge clk);
    check("t1.still_valid", 32'(cmd_if.cmd_valid), 1);
    accept_cmd();
    exp_ok++;
    check("t1.valid_after", 32'(cmd_if.cmd_valid), 0);
    check("t1.state_after", 32'(state), 0);
    check_cnts("t1");

    // Garbage then zero-length frame; stale buffer byte must be masked
    send_byte(8'h55);
    send_byte(8'h00);
    check("t2.hunt", 32'(state), 0);
    send_byte(8'hAA); send_byte(8'h33); send_byte(8'h00); send_byte(8'h33);
    check("t2.valid",  32'(cmd_if.cmd_valid), 1);
    check("t2.opcode", 32'(cmd_if.cmd_opcode), 32'h33);
    check("t2.len",    32'(cmd_if.cmd_len), 0);
    check_rd(0, 8'h00);
    check_cnts("t2");

    // Overrun while holding: byte discarded, command unchanged
    send_byte(8'h77);
    exp_err++;
    check("t2o.valid",  32'(cmd_if.cmd_valid), 1);
    check("t2o.opcode", 32'(cmd_if.cmd_opcode), 32'h33);
    check("t2o.len",    32'(cmd_if.cmd_len), 0);
    check_cnts("t2o");
    accept_cmd();
    exp_ok++;
    check_cnts("t2r");

    // Bad checksum, then a short good frame
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h05); send_byte(8'h07); send_byte(8'h1F);
    exp_err++;
    check("t3.valid", 32'(cmd_if.cmd_valid), 0);
    check("t3.state", 32'(state), 0);
    check_cnts("t3");
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    check("t3g.valid",  32'(cmd_if.cmd_valid), 1);
    check("t3g.opcode", 32'(cmd_if.cmd_opcode), 32'h01);

    // Handshake and overrun byte on the same cycle
    @(negedge clk);
    cmd_if.cmd_ready = 1'b1;
    rx_data = 8'h99;
    rx_valid = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ready = 1'b0;
    rx_valid = 1'b0;
    exp_ok++;
    exp_err++;
    check("t3h.valid", 32'(cmd_if.cmd_valid), 0);
    check("t3h.state", 32'(state), 0);
    check_cnts("t3h");

    // Oversize length, following bytes ignored
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h11);
    exp_err++;
    check("t4.state", 32'(state), 0);
    send_byte(8'h10); send_byte(8'h05);
    check("t4.ignored", 32'(state), 0);
    check_cnts("t4");

    // Frame error with a coincident byte in LEN
    send_byte(8'hAA); send_byte(8'h10);
    check("t5.len_state", 32'(state), 2);
    @(negedge clk);
    rx_data = 8'h02; rx_valid = 1'b1; rx_frame_error = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_frame_error = 1'b0;
    exp_err++;
    check("t5.fe_state", 32'(state), 0);
    check_cnts("t5");

    // Length == MAX_LEN accepted, then frame error in PAYLOAD
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h10);
    check("t5m.state", 32'(state), 3);
    check("t5m.len",   32'(cmd_if.cmd_len), 16);
    @(negedge clk);
    rx_frame_error = 1'b1;
    @(negedge clk);
    rx_frame_error = 1'b0;
    exp_err++;
    check("t5m.fe_state", 32'(state), 0);
    check_cnts("t5m");

    // Inter-byte timeout inside PAYLOAD
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02); send_byte(8'h05);
    repeat (TMO - 1) @(negedge clk);
    check("t6.before_tmo", 32'(state), 3);
    @(negedge clk);
    exp_err++;
    check("t6.after_tmo", 32'(state), 0);
    check("t6.busy",      32'(busy), 0);
    check_cnts("t6");

    // Asynchronous reset mid-PAYLOAD
    send_byte(8'hAA); send_byte(8'h42); send_byte(8'h03); send_byte(8'h01);
    check("t7.state", 32'(state), 3);
    check("t7.len",   32'(cmd_if.cmd_len), 3);
    #2;
    rst_n = 1'b0;
    #1;
    exp_ok = 0;
    exp_err = 0;
    check("t7.rst_state",  32'(state), 0);
    check("t7.rst_opcode", 32'(cmd_if.cmd_opcode), 0);
    check("t7.rst_len",    32'(cmd_if.cmd_len), 0);
    check("t7.rst_busy",   32'(busy), 0);
    check("t7.rst_valid",  32'(cmd_if.cmd_valid), 0);
    check_cnts("t7");
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery after reset
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h01);
    send_byte(8'h09); send_byte(8'h0F);
    check("t8.valid",  32'(cmd_if.cmd_valid), 1);
    check("t8.opcode", 32'(cmd_if.cmd_opcode), 32'h05);
    check_rd(0, 8'h09);
    check_rd(1, 8'h00);
    accept_cmd();
    exp_ok++;
    check_cnts("t8");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
